buffer_capture_sequencer: RTL
=============================

Name: buffer_capture_sequencer

Overview:
- Capture-clock-domain controller for the dual-clock BRAM capture buffer.
- Turns software arm/stop/reset commands and an external trigger into the buffer's start, stop and software-reset pulses.
- Enforces an optional capture length and tracks buffer status.
- Protects a completed capture from being overwritten until readout-done is seen.

Parameters:
- CHANNELS, 8, number of buffer channels; sets banking-mode width.
- LENGTH_WIDTH, 32, width of the capture-length config and the beat counter.
- STOP_DELAY, 4, cycles waited after the stop pulse to let the buffer write pipeline drain.

Ports:
- capture_clk  in  1  capture clock.
- capture_reset  in  1  synchronous, active-high reset.
- cfg_banking_mode  in  $clog2($clog2(CHANNELS)+1)  requested banking mode.
- cfg_length  in  LENGTH_WIDTH  valid beats to capture; 0 = unlimited (run until full or stop).
- cmd_arm  in  1  level; rising edge arms.
- cmd_stop  in  1  level; rising edge stops.
- cmd_sw_reset  in  1  level; any cycle high aborts.
- trigger  in  1  level; starts capture while armed.
- capture_valid  in  1  input data beat valid (channel 0 valid).
- capture_full  in  1  buffer full flag.
- readout_done  in  1  single-cycle pulse; DMA readout finished, already synchronized to capture_clk.
- capture_banking_mode  out  same as cfg_banking_mode  mode latched at arm.
- capture_start  out  1  single-cycle start pulse to buffer.
- capture_stop  out  1  single-cycle stop pulse to buffer.
- capture_sw_reset  out  1  single-cycle reset pulse to buffer.
- seq_state  out  3  current state encoding.
- beat_count  out  LENGTH_WIDTH  valid beats counted in the current capture.
- data_ready  out  1  buffer holds a completed capture.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal edge-detect registers 0.
- All outputs are registered.
- Pulse outputs are exactly 1 cycle wide and never asserted on consecutive cycles, because the buffer edge-detects them.
- States and encodings: IDLE=0, ARMED=1, CAPTURING=2, STOPPING=3, DONE=4.
- IDLE:
  - On cmd_arm rising edge: latch cfg_banking_mode and cfg_length.
  - Pulse capture_sw_reset the next cycle.
  - Go to ARMED.
- ARMED:
  - trigger high: capture_start pulses on the following cycle; beat_count cleared to 0; go to CAPTURING.
  - cmd_stop rising edge: go to IDLE with no pulses.
  - Stop and trigger in the same cycle: stop wins.
- CAPTURING:
  - beat_count increments on each capture_valid and saturates at all-ones.
  - Terminate on the first of:
    - cmd_stop rising edge;
    - capture_full high;
    - latched length != 0 and capture_valid while beat_count == length-1 (final count equals length).
  - On terminate: capture_stop pulses next cycle; go to STOPPING.
  - Several terminate causes in the same cycle produce a single stop pulse.
  - The buffer may self-disable on full, but capture_stop is still pulsed.
- STOPPING:
  - Counter runs STOP_DELAY cycles.
  - Then go to DONE; data_ready goes to 1 on entry to DONE.
- DONE:
  - Hold data_ready = 1.
  - cmd_arm is ignored (data protected).
  - readout_done pulse: data_ready goes to 0; go to IDLE.
- readout_done is ignored in every state other than DONE.
- cmd_sw_reset, from any state:
  - Next state is IDLE; data_ready goes to 0.
  - capture_sw_reset pulses; additionally capture_stop pulses if the state was CAPTURING.
  - Takes priority over every other input except capture_reset.
- Priority order: capture_reset > cmd_sw_reset > cmd_stop > capture_full > length reached > trigger > cmd_arm.
- Rising-edge detect on cmd_arm/cmd_stop uses 1-cycle-delayed copies. A command held high across a reset does not generate an edge until it goes low and then high again.
- beat_count holds its value through STOPPING and DONE, and is cleared at the next trigger.
- capture_reset mid-capture: all outputs return to 0 in the next cycle with no stop pulse. The buffer is reset by the same reset.

Decomposition:
- Package buffer_ctrl_pkg:
  - seq_state_t enum (3-bit, encodings above);
  - localparam for banking-mode width as a function of CHANNELS.
- Sub-module rising_edge_detect (1-bit, registered; output = in & ~in_d), instantiated for cmd_arm and cmd_stop.
- FSM and counters stay in the top module.

Test Plan:
- Arm, trigger, cfg_length=10, continuous valid:
  - capture_sw_reset pulse 1 cycle after the arm edge;
  - capture_start 1 cycle after trigger;
  - capture_stop pulse after the 10th beat with beat_count=10;
  - data_ready high 4 cycles after the stop pulse.
- cfg_length=0, capture_full asserted after 256 beats: exactly one capture_stop pulse; DONE; beat_count=256.
- DONE, then cmd_arm edge: no pulses and state stays 4. Then readout_done pulse: data_ready goes to 0, state 0; a re-arm is accepted.
- ARMED with trigger and cmd_stop edge in the same cycle: no capture_start; state returns to 0.
- cmd_sw_reset while CAPTURING: capture_stop and capture_sw_reset both pulse 1 cycle later; state 0; data_ready 0.
- capture_full, cmd_stop edge and length-reached all in the same cycle: single capture_stop pulse. Then hold cmd_arm high through capture_reset: no arm until cmd_arm toggles.

Source files
------------

// File: rtl/buffer_ctrl_pkg.sv
// Shared types and sizing helpers for the capture buffer controller.
package buffer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_CAPTURING = 3'd2,
    ST_STOPPING  = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_t;

  localparam int DEFAULT_CHANNELS = 8;

  // Banking mode selects 1..CHANNELS banks in powers of two, so it needs
  // enough bits to hold log2(CHANNELS); never narrower than one bit.
  function automatic int bank_mode_width(input int channels);
    int w;
    w = $clog2($clog2(channels) + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int BANK_MODE_WIDTH = bank_mode_width(DEFAULT_CHANNELS);

endpackage

// File: rtl/rising_edge_detect.sv
// One-bit rising-edge detector for level-style software commands.
module rising_edge_detect (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise
);

  logic din_d_q;
  logic din_d_d;
  logic hold_q;
  logic hold_d;

  // A level already high when reset is applied must drop before it can
  // count as a new command, so hold blocks the edge until din is seen low.
  always_comb begin
    din_d_d = din;
    hold_d  = hold_q & din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      din_d_q <= 1'b0;
      hold_q  <= din;
    end else begin
      din_d_q <= din_d_d;
      hold_q  <= hold_d;
    end
  end

  assign rise = din & ~din_d_q & ~hold_q;

endmodule

// File: rtl/buffer_capture_sequencer.sv
// Capture-domain sequencer: turns arm/stop/reset commands and a trigger into
// start/stop/reset pulses for the BRAM capture buffer and tracks its status.
module buffer_capture_sequencer
  import buffer_ctrl_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int LENGTH_WIDTH = 32,
  parameter int STOP_DELAY   = 4
) (
  input  logic                                 capture_clk,
  input  logic                                 capture_reset,
  input  logic [bank_mode_width(CHANNELS)-1:0] cfg_banking_mode,
  input  logic [LENGTH_WIDTH-1:0]              cfg_length,
  input  logic                                 cmd_arm,
  input  logic                                 cmd_stop,
  input  logic                                 cmd_sw_reset,
  input  logic                                 trigger,
  input  logic                                 capture_valid,
  input  logic                                 capture_full,
  input  logic                                 readout_done,
  output logic [bank_mode_width(CHANNELS)-1:0] capture_banking_mode,
  output logic                                 capture_start,
  output logic                                 capture_stop,
  output logic                                 capture_sw_reset,
  output logic [2:0]                           seq_state,
  output logic [LENGTH_WIDTH-1:0]              beat_count,
  output logic                                 data_ready
);

  localparam int BMW   = bank_mode_width(CHANNELS);
  localparam int DLY_W = (STOP_DELAY > 1) ? $clog2(STOP_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = (STOP_DELAY > 1) ? DLY_W'(STOP_DELAY - 1) : '0;

  logic arm_rise;
  logic stop_rise;

  rising_edge_detect u_arm_edge (
    .clk  (capture_clk),
    .srst (capture_reset),
    .din  (cmd_arm),
    .rise (arm_rise)
  );

  rising_edge_detect u_stop_edge (
    .clk  (capture_clk),
    .srst (capture_reset),
    .din  (cmd_stop),
    .rise (stop_rise)
  );

  seq_state_t              state_q, state_d;
  logic [BMW-1:0]          bank_q, bank_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [LENGTH_WIDTH-1:0] beat_q, beat_d;
  logic [DLY_W-1:0]        delay_q, delay_d;
  logic                    start_q, start_d;
  logic                    stop_q, stop_d;
  logic                    swr_q, swr_d;
  logic                    ready_q, ready_d;
  logic                    len_hit;

  // Length reached means this beat makes the count equal the latched length.
  assign len_hit = (len_q != '0) && capture_valid && (beat_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    len_d   = len_q;
    beat_d  = beat_q;
    delay_d = delay_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    swr_d   = 1'b0;
    ready_d = ready_q;

    if (cmd_sw_reset) begin
      // Gated by swr_q so a held abort cannot produce back-to-back pulses.
      state_d = ST_IDLE;
      ready_d = 1'b0;
      swr_d   = ~swr_q;
      stop_d  = (state_q == ST_CAPTURING);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_rise) begin
            bank_d  = cfg_banking_mode;
            len_d   = cfg_length;
            swr_d   = ~swr_q;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (stop_rise) begin
            state_d = ST_IDLE;
          end else if (trigger) begin
            start_d = 1'b1;
            beat_d  = '0;
            state_d = ST_CAPTURING;
          end
        end
        ST_CAPTURING: begin
          if (capture_valid && (beat_q != '1)) begin
            beat_d = beat_q + 1'b1;
          end
          if (stop_rise || capture_full || len_hit) begin
            stop_d  = 1'b1;
            delay_d = '0;
            state_d = ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          if (delay_q == DLY_LAST) begin
            ready_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            delay_d = delay_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (readout_done) begin
            ready_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge capture_clk) begin
    if (capture_reset) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      delay_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      swr_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      delay_q <= delay_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      swr_q   <= swr_d;
      ready_q <= ready_d;
    end
  end

  assign capture_banking_mode = bank_q;
  assign capture_start        = start_q;
  assign capture_stop         = stop_q;
  assign capture_sw_reset     = swr_q;
  assign seq_state            = state_q;
  assign beat_count           = beat_q;
  assign data_ready           = ready_q;

endmodule
